// File: rtl/pipelined_adder_if.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_adder_if
// Purpose  : Operand/result bundle for pipelined_adder. It carries the input
//            handshake, the operands and mode bits, the synchronous flush, the
//            output handshake and the result flags.
// Modports : master - the producer/consumer side (drives operands, out_ready)
//            slave  - the adder side (drives in_ready and the results)
// Ports    : flush, in_valid, in_ready, a, b, cin, sub,
//            out_valid, out_ready, sum, cout, ovf
//            zero, neg (only when PIPELINED_ADDER_FLAGS_EN is defined)
// Macro    : PIPELINED_ADDER_FLAGS_EN adds the zero/neg result flags.
// Revision : 1.0 - initial release
// ============================================================================
interface pipelined_adder_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
`ifdef PIPELINED_ADDER_FLAGS_EN
    logic             zero;
    logic             neg;
`endif

    modport master (
        output flush, in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
`ifdef PIPELINED_ADDER_FLAGS_EN
        , input zero, neg
`endif
    );

    modport slave (
        input  flush, in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
`ifdef PIPELINED_ADDER_FLAGS_EN
        , output zero, neg
`endif
    );
endinterface

`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_adder
// Purpose  : WIDTH-bit adder/subtractor whose carry chain is cut into STAGES
//            equal chunks, one chunk added per pipeline stage. One operation
//            per cycle, latency STAGES cycles. A single global stall
//            (out_valid & ~out_ready) freezes every stage; flush clears all
//            valid bits at the next edge.
// Ports    : clk  - clock, rising edge
//            rst  - asynchronous active-high reset
//            bus  - pipelined_adder_if.slave (handshakes, operands, results)
// Params   : WIDTH  - operand width, must be a multiple of STAGES
//            STAGES - pipeline depth, 1..WIDTH
// Macro    : PIPELINED_ADDER_FLAGS_EN adds registered zero/neg result flags.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    pipelined_adder_if.slave bus
);
    localparam int CW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    logic             stall;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    assign stall        = bus.out_valid & ~bus.out_ready;
    assign bus.in_ready = ~stall;

    // Subtraction is a + ~b + 1; cin toggles the +1 so sub with cin=1 is a-b-1.
    assign b_eff = bus.sub ? ~bus.b : bus.b;
    assign c_eff = bus.cin ^ bus.sub;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // RW: operand bits still to be added when entering this stage.
        // SW: result bits known once this stage has added its chunk.
        localparam int RW = WIDTH - k * CW;
        localparam int SW = (k + 1) * CW;

        logic [RW-1:0] a_src;
        logic [RW-1:0] b_src;
        logic          c_in;
        logic          v_in;
        logic [CW:0]   ch_sum;
        logic [SW-1:0] s_d;

        logic          v_q;
        logic          c_q;
        logic [SW-1:0] s_q;

        if (k == 0) begin : g_first
            assign a_src = bus.a;
            assign b_src = b_eff;
            assign c_in  = c_eff;
            assign v_in  = bus.in_valid;
            assign s_d   = ch_sum[CW-1:0];
        end else begin : g_next
            assign a_src = g_stage[k-1].g_fwd.a_q;
            assign b_src = g_stage[k-1].g_fwd.b_q;
            assign c_in  = g_stage[k-1].c_q;
            assign v_in  = g_stage[k-1].v_q;
            // Lower chunks travel unchanged; this stage appends its own chunk.
            assign s_d   = {ch_sum[CW-1:0], g_stage[k-1].s_q};
        end

        assign ch_sum = {1'b0, a_src[CW-1:0]} + {1'b0, b_src[CW-1:0]}
                      + {{CW{1'b0}}, c_in};

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else begin
                // Flush wins over stall; data may keep stale contents.
                if (bus.flush) begin
                    v_q <= 1'b0;
                end else if (!stall) begin
                    v_q <= v_in;
                end
                if (!stall) begin
                    c_q <= ch_sum[CW];
                    s_q <= s_d;
                end
            end
        end

        // Operand chunks not yet consumed ride along to the later stages.
        if (k < LAST) begin : g_fwd
            logic [RW-CW-1:0] a_q;
            logic [RW-CW-1:0] b_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (!stall) begin
                    a_q <= a_src[RW-1:CW];
                    b_q <= b_src[RW-1:CW];
                end
            end
        end

        if (k == LAST) begin : g_last
            logic c_msb;
            logic ovf_q;

            // Carry into the MSB recovered from the MSB sum bit and operands.
            assign c_msb = a_src[CW-1] ^ b_src[CW-1] ^ ch_sum[CW-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (!stall) begin
                    ovf_q <= c_msb ^ ch_sum[CW];
                end
            end
        end

`ifdef PIPELINED_ADDER_FLAGS_EN
        // Zero is accumulated one chunk at a time so that the output never
        // sees a full-width NOR.
        logic z_in;
        logic z_q;

        if (k == 0) begin : g_zfirst
            assign z_in = 1'b1;
        end else begin : g_znext
            assign z_in = g_stage[k-1].z_q;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                z_q <= 1'b0;
            end else if (!stall) begin
                z_q <= z_in & (ch_sum[CW-1:0] == '0);
            end
        end
`endif
    end

    assign bus.out_valid = g_stage[LAST].v_q;
    assign bus.sum       = g_stage[LAST].s_q;
    assign bus.cout      = g_stage[LAST].c_q;
    assign bus.ovf       = g_stage[LAST].g_last.ovf_q;
`ifdef PIPELINED_ADDER_FLAGS_EN
    assign bus.zero      = g_stage[LAST].z_q;
    assign bus.neg       = g_stage[LAST].s_q[WIDTH-1];
`endif

endmodule

`default_nettype wire
